textlcd_ctrl: RTL and testbench

Parametrised HD44780-class character-LCD controller with an internal character buffer. It runs the power-on init sequence, then streams the buffer to the panel one bus slot at a time, either continuously or on request. The geometry (lines, columns, line base addresses) and bus timing are parameters. A host-side byte write port updates the buffer at any time, and writes that arrive mid-refresh are never lost. It sits between register/bus logic and the LCD pins.

---
 rtl/textlcd_pkg.sv | 36 +++
 rtl/textlcd_charbuf.sv | 38 +++
 rtl/textlcd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_textlcd_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/textlcd_pkg.sv
// textlcd_pkg: shared types and constants for the character-LCD controller.
//   state_e      - controller FSM states, one bus slot per step
//   CMD_*        - HD44780 command bytes issued during init and addressing
//   CHAR_SPACE   - reset contents of every character buffer entry
//   line_base()  - picks one DDRAM base address out of the packed table
package textlcd_pkg;

    typedef enum logic [3:0] {
        PWRON       = 4'd0,
        FNSET       = 4'd1,
        ONOFF       = 4'd2,
        ENTRY       = 4'd3,
        HOME        = 4'd4,
        CLEAR       = 4'd5,
        CLRWAIT     = 4'd6,
        SETA        = 4'd7,
        WRCH        = 4'd8,
        REFRESH_END = 4'd9,
        IDLE        = 4'd10
    } state_e;

    localparam logic [7:0] CMD_FNSET  = 8'h38;
    localparam logic [7:0] CMD_ONOFF  = 8'h0E;
    localparam logic [7:0] CMD_ENTRY  = 8'h06;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_SETA   = 8'h80;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // The base table is written {line0, line1, line2, line3}, so line 0
    // occupies the most significant byte.
    function automatic logic [7:0] line_base(input logic [31:0] bases, input int line);
        return bases[8*(3-line) +: 8];
    endfunction

endpackage

// File: rtl/textlcd_charbuf.sv
// textlcd_charbuf: character buffer, DEPTH x 8 register file.
//   clk, resetn      - clock, asynchronous active-low reset (fills with spaces)
//   wr_en_i          - write strobe; writes land on the next clk edge
//   wr_addr_i        - write index; indices >= DEPTH are ignored
//   wr_data_i        - character code to store
//   rd_addr_i        - combinational read index
//   rd_data_o        - character at rd_addr_i (space for out-of-range indices)
module textlcd_charbuf
    import textlcd_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CHAR_SPACE;
            end
        end else if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A read and a write to the same index in one cycle return the old byte.
    assign rd_data_o = (int'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : CHAR_SPACE;

endmodule

// File: rtl/textlcd_ctrl.sv
// textlcd_ctrl: HD44780-class character-LCD controller with internal buffer.
// Runs the power-on init sequence, then streams the character buffer to the
// panel one bus slot (CLK_DIV cycles) at a time.
//   clk, resetn   - clock, asynchronous active-low reset
//   wr_en         - single-cycle buffer write strobe
//   wr_addr       - buffer index = line*NUM_COLS + col
//   wr_data       - character code
//   refresh_req   - request one refresh pass (needed when AUTO_REFRESH = 0)
//   init_done     - high once the init sequence and clear wait have finished
//   busy          - high during init and during a refresh pass
//   lcd_rs        - register select (0 command, 1 data), stable per slot
//   lcd_rw        - tied low, the panel is only written
//   lcd_en        - enable strobe, high for EN_RISE..EN_FALL-1 of active slots
//   lcd_data      - command/data byte, stable per slot
//   dbg_state_o   - current FSM state
//
// Handshake: there is no back-pressure. A wr_en pulse is accepted in the
// cycle it is high; refresh_req is a single-cycle pulse latched into a
// pending flag and serviced at a later slot boundary.
module textlcd_ctrl
    import textlcd_pkg::*;
#(
    parameter int          CLK_DIV      = 2000,
    parameter int          EN_RISE      = 200,
    parameter int          EN_FALL      = 1800,
    parameter int          NUM_LINES    = 2,
    parameter int          NUM_COLS     = 16,
    parameter logic [31:0] LINE_BASE    = {8'h00, 8'h40, 8'h14, 8'h54},
    parameter int          CLR_SLOTS    = 2,
    parameter int          AUTO_REFRESH = 1,
    localparam int         DEPTH        = NUM_LINES * NUM_COLS,
    localparam int         AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          refresh_req,
    output logic          init_done,
    output logic          busy,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_data,
    output state_e        dbg_state_o
);

    localparam int CTW = $clog2(CLK_DIV);
    localparam int LW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int WW  = (CLR_SLOTS > 1) ? $clog2(CLR_SLOTS) : 1;

    state_e         state_q, state_d;
    logic [CTW-1:0] cnt_q, cnt_d;
    logic [LW-1:0]  line_q, line_d;
    logic [CW-1:0]  col_q, col_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic           pending_q, pending_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;
    logic           en_q, en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           slot_end;
    logic           slot_active;
    logic           in_refresh;
    logic           wr_ok;
    logic           start_refresh;
    logic           done_set;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data;

    // ------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------
    assign slot_end = (cnt_q == CTW'(CLK_DIV - 1));
    assign cnt_d    = slot_end ? '0 : cnt_q + CTW'(1);

    // Clear wait, idle and the (zero-length) end-of-refresh point never pulse en.
    assign slot_active = !(state_q inside {CLRWAIT, IDLE, REFRESH_END});

    // en is registered against the next counter value so that it is high
    // exactly while cnt_q is in EN_RISE..EN_FALL-1. EN_RISE > 0 means the
    // rising point is never the wrap cycle, so state_q is the right slot.
    assign en_d = slot_active && (cnt_d >= CTW'(EN_RISE)) && (cnt_d < CTW'(EN_FALL));

    // ------------------------------------------------------------------
    // Pending-refresh flag
    // ------------------------------------------------------------------
    assign wr_ok      = wr_en && (int'(wr_addr) < DEPTH);
    assign in_refresh = state_q inside {CLRWAIT, SETA, WRCH, REFRESH_END};

    // Set wins over the clear issued when a refresh starts in the same cycle.
    assign pending_d = refresh_req || (wr_ok && in_refresh) || (pending_q && !start_refresh);

    // ------------------------------------------------------------------
    // Next-state logic: transitions happen only at slot boundaries
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        col_d         = col_q;
        wait_d        = wait_q;
        start_refresh = 1'b0;
        done_set      = 1'b0;

        if (slot_end) begin
            unique case (state_q)
                PWRON: state_d = FNSET;
                FNSET: state_d = ONOFF;
                ONOFF: state_d = ENTRY;
                ENTRY: state_d = HOME;
                HOME:  state_d = CLEAR;
                CLEAR: begin
                    if (CLR_SLOTS == 0) begin
                        state_d       = SETA;
                        line_d        = '0;
                        start_refresh = 1'b1;
                        done_set      = 1'b1;
                    end else begin
                        state_d = CLRWAIT;
                        wait_d  = '0;
                    end
                end
                CLRWAIT: begin
                    if (int'(wait_q) >= CLR_SLOTS - 1) begin
                        state_d       = SETA;
                        line_d        = '0;
                        start_refresh = 1'b1;
                        done_set      = 1'b1;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                SETA: begin
                    state_d = WRCH;
                    col_d   = '0;
                end
                WRCH: begin
                    if (int'(col_q) == NUM_COLS - 1) begin
                        if (int'(line_q) == NUM_LINES - 1) begin
                            // End of refresh is resolved here rather than in a
                            // slot of its own, so a pass is exactly
                            // NUM_LINES*(1+NUM_COLS) slots long.
                            if ((AUTO_REFRESH != 0) || pending_q) begin
                                state_d       = SETA;
                                line_d        = '0;
                                start_refresh = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = SETA;
                            line_d  = line_q + LW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                REFRESH_END: begin
                    if ((AUTO_REFRESH != 0) || pending_q) begin
                        state_d       = SETA;
                        line_d        = '0;
                        start_refresh = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (pending_q) begin
                        state_d       = SETA;
                        line_d        = '0;
                        start_refresh = 1'b1;
                    end
                end
                default: state_d = PWRON;
            endcase
        end
    end

    // Buffer index for the character of the slot about to start.
    assign rd_addr = AW'(int'(line_d) * NUM_COLS + int'(col_d));

    textlcd_charbuf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_charbuf (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // ------------------------------------------------------------------
    // Bus outputs for the next slot, loaded only at the slot boundary
    // ------------------------------------------------------------------
    always_comb begin
        rs_d   = rs_q;
        data_d = data_q;
        busy_d = busy_q;
        done_d = done_q || done_set;

        if (slot_end) begin
            busy_d = (state_d != IDLE);
            unique case (state_d)
                PWRON, FNSET: begin
                    rs_d   = 1'b0;
                    data_d = CMD_FNSET;
                end
                ONOFF: begin
                    rs_d   = 1'b0;
                    data_d = CMD_ONOFF;
                end
                ENTRY: begin
                    rs_d   = 1'b0;
                    data_d = CMD_ENTRY;
                end
                HOME: begin
                    rs_d   = 1'b0;
                    data_d = CMD_HOME;
                end
                CLEAR: begin
                    rs_d   = 1'b0;
                    data_d = CMD_CLEAR;
                end
                SETA: begin
                    rs_d   = 1'b0;
                    data_d = CMD_SETA | line_base(LINE_BASE, int'(line_d));
                end
                WRCH: begin
                    rs_d   = 1'b1;
                    data_d = rd_data;
                end
                // Inactive slots keep the previous byte on the bus.
                default: begin
                    rs_d   = rs_q;
                    data_d = data_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= PWRON;
            cnt_q     <= '0;
            line_q    <= '0;
            col_q     <= '0;
            wait_q    <= '0;
            pending_q <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= CMD_FNSET;
            en_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            col_q     <= col_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign init_done   = done_q;
    assign busy        = busy_q;
    assign lcd_rs      = rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_en      = en_q;
    assign lcd_data    = data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_textlcd_ctrl.sv
// Bench for textlcd_ctrl. dut1 is a 2x16 panel with a 20-cycle slot and
// requested refresh; dut2 is a 1x3 panel with a 4-cycle slot, used where a
// buffer index past the end is representable on wr_addr.
module tb_textlcd_ctrl;
    import textlcd_pkg::*;

    localparam int DIV  = 20;
    localparam int EN_W = 16;   // EN_FALL - EN_RISE

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut1 ----------------
    logic       wr_en, refresh_req;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;
    state_e     dbg_state;

    textlcd_ctrl #(
        .CLK_DIV(DIV), .EN_RISE(2), .EN_FALL(18), .NUM_LINES(2), .NUM_COLS(16),
        .CLR_SLOTS(2), .AUTO_REFRESH(0)
    ) dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh_req(refresh_req), .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data), .dbg_state_o(dbg_state)
    );

    // ---------------- dut2 ----------------
    logic       wr_en2, refresh_req2;
    logic [1:0] wr_addr2;
    logic [7:0] wr_data2;
    logic       init_done2, busy2, lcd_rs2, lcd_rw2, lcd_en2;
    logic [7:0] lcd_data2;
    state_e     dbg_state2;

    textlcd_ctrl #(
        .CLK_DIV(4), .EN_RISE(1), .EN_FALL(3), .NUM_LINES(1), .NUM_COLS(3),
        .CLR_SLOTS(1), .AUTO_REFRESH(0)
    ) dut2 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .refresh_req(refresh_req2), .init_done(init_done2), .busy(busy2), .lcd_rs(lcd_rs2),
        .lcd_rw(lcd_rw2), .lcd_en(lcd_en2), .lcd_data(lcd_data2), .dbg_state_o(dbg_state2)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    int busy_cycles = 0;
    int slot_idx = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         en_cyc;
        logic       busy;
        logic       done;
        int         wr_cyc;    // slot cycle at which wr_en is driven, -1 none
        logic [4:0] wr_addr;
        logic [7:0] wr_data;
        int         req_cyc;   // slot cycle at which refresh_req is driven, -1 none
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] model [32];
    logic [8:0] exp_q[$];
    logic [8:0] got2_q[$];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- dut2 bus monitor ----------------
    logic en2_prev = 1'b0;
    always @(negedge clk) begin
        if (lcd_en2 && !en2_prev) got2_q.push_back({lcd_rs2, lcd_data2});
        en2_prev = lcd_en2;
    end

    // ---------------- vector builders ----------------
    function automatic vec_t mk(input logic rs, input logic [7:0] d, input int en,
                                input logic b, input logic dn);
        vec_t v;
        v.rs = rs; v.data = d; v.en_cyc = en; v.busy = b; v.done = dn;
        v.wr_cyc = -1; v.wr_addr = '0; v.wr_data = '0; v.req_cyc = -1;
        return v;
    endfunction

    task automatic push_init();
        logic [7:0] cmds [6];
        cmds[0] = 8'h38; cmds[1] = 8'h38; cmds[2] = 8'h0E;
        cmds[3] = 8'h06; cmds[4] = 8'h02; cmds[5] = 8'h01;
        for (int i = 0; i < 6; i++) vecs.push_back(mk(1'b0, cmds[i], EN_W, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 8'h01, 0, 1'b1, 1'b0));
    endtask

    // One full pass from the model; optionally inject a write at pass slot ws.
    task automatic push_refresh(input int ws, input int wc, input logic [4:0] wa,
                                input logic [7:0] wd);
        vec_t v;
        int   k = 0;
        for (int l = 0; l < 2; l++) begin
            v = mk(1'b0, (l == 0) ? 8'h80 : 8'hC0, EN_W, 1'b1, 1'b1);
            if (k == ws) begin v.wr_cyc = wc; v.wr_addr = wa; v.wr_data = wd; end
            vecs.push_back(v);
            k++;
            for (int c = 0; c < 16; c++) begin
                v = mk(1'b1, model[l*16+c], EN_W, 1'b1, 1'b1);
                if (k == ws) begin v.wr_cyc = wc; v.wr_addr = wa; v.wr_data = wd; end
                vecs.push_back(v);
                k++;
            end
        end
    endtask

    function automatic vec_t idle_vec();
        return mk(1'b1, model[31], 0, 1'b0, 1'b1);
    endfunction

    // ---------------- driver / checker ----------------
    task automatic run_slot(input vec_t v);
        int         en_n;
        int         bad;
        logic [11:0] seen;
        logic [11:0] want;
        en_n = 0; bad = 0; seen = '0;
        want = {v.rs, v.busy, v.done, 1'b0, v.data};
        for (int c = 0; c < DIV; c++) begin
            wr_en       = (c == v.wr_cyc);
            wr_addr     = v.wr_addr;
            wr_data     = v.wr_data;
            refresh_req = (c == v.req_cyc);
            if (lcd_en) en_n++;
            if (busy) busy_cycles++;
            if ({lcd_rs, busy, init_done, lcd_rw, lcd_data} !== want) begin
                if (bad == 0) seen = {lcd_rs, busy, init_done, lcd_rw, lcd_data};
                bad++;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        refresh_req = 1'b0;
        check(bad == 0, $sformatf("slot%0d_rs_busy_done_rw_data", slot_idx), int'(seen), int'(want));
        check(en_n == v.en_cyc, $sformatf("slot%0d_en_cycles", slot_idx), en_n, v.en_cyc);
        slot_idx++;
    endtask

    task automatic run_vecs();
        while (vecs.size() > 0) run_slot(vecs.pop_front());
    endtask

    task automatic check_dut2_bytes(input string tag);
        logic [8:0] e, g;
        check(got2_q.size() == exp_q.size(), {tag, "_byte_count"}, got2_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got2_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got2_q.pop_front();
            check(g == e, {tag, "_rs_byte"}, int'(g), int'(e));
        end
        exp_q.delete();
        got2_q.delete();
    endtask

    // ---------------- test sequence ----------------
    vec_t v;

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; refresh_req = 1'b0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; refresh_req2 = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;

        repeat (3) @(negedge clk);
        check(int'(dbg_state) == int'(PWRON), "reset_state", int'(dbg_state), int'(PWRON));
        check(lcd_en == 1'b0, "reset_en", lcd_en, 0);
        resetn = 1'b1;

        // Init sequence, default refresh, then idle.
        push_init();
        push_refresh(-1, 0, '0, '0);
        vecs.push_back(idle_vec());
        run_vecs();

        // Requested refresh after writing index 17 in idle.
        busy_cycles = 0;
        v = idle_vec();
        v.wr_cyc = 0; v.wr_addr = 5'd17; v.wr_data = 8'h41; v.req_cyc = 1;
        vecs.push_back(v);
        model[17] = 8'h41;
        push_refresh(-1, 0, '0, '0);
        vecs.push_back(idle_vec());
        run_vecs();
        check(busy_cycles == 34 * DIV, "busy_cycles_one_pass", busy_cycles, 34 * DIV);

        // Write during refresh, then a write on the sampling boundary.
        v = idle_vec();
        v.req_cyc = 0;
        vecs.push_back(v);
        push_refresh(2, 0, 5'd0, 8'h5A);        // char1 slot: index 0 already shown
        model[0] = 8'h5A;
        push_refresh(0, DIV - 1, 5'd0, 8'h51);  // last SETA cycle: char0 sampled old
        model[0] = 8'h51;
        push_refresh(-1, 0, '0, '0);
        vecs.push_back(idle_vec());
        run_vecs();

        // Out-of-range write on dut2 (index 3 of a 3-entry buffer).
        exp_q = '{9'h038, 9'h038, 9'h00E, 9'h006, 9'h002, 9'h001,
                  9'h080, 9'h120, 9'h120, 9'h120};
        check_dut2_bytes("dut2_first_pass");
        wr_en2 = 1'b1; wr_addr2 = 2'd3; wr_data2 = 8'h58;
        @(negedge clk);
        wr_en2 = 1'b0;
        repeat (39) @(negedge clk);
        check(got2_q.size() == 0, "oor_no_bus_traffic", got2_q.size(), 0);
        check(busy2 == 1'b0, "oor_busy", busy2, 0);
        check(int'(dbg_state2) == int'(IDLE), "oor_state", int'(dbg_state2), int'(IDLE));
        wr_en2 = 1'b1; wr_addr2 = 2'd2; wr_data2 = 8'h42;
        @(negedge clk);
        wr_en2 = 1'b0; refresh_req2 = 1'b1;
        @(negedge clk);
        refresh_req2 = 1'b0;
        repeat (38) @(negedge clk);
        exp_q = '{9'h080, 9'h120, 9'h120, 9'h142};
        check_dut2_bytes("dut2_after_oor");
        check(busy == 1'b0, "dut1_still_idle", busy, 0);

        // Reset in the middle of a WRCH slot.
        v = idle_vec();
        v.req_cyc = 0;
        vecs.push_back(v);
        vecs.push_back(mk(1'b0, 8'h80, EN_W, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, model[0], EN_W, 1'b1, 1'b1));
        run_vecs();
        repeat (10) @(negedge clk);
        check(lcd_en == 1'b1, "en_before_reset", lcd_en, 1);
        resetn = 1'b0;
        #1;
        check(lcd_en == 1'b0, "en_async_drop", lcd_en, 0);
        check({lcd_rs, lcd_data} == 9'h038, "reset_rs_data", int'({lcd_rs, lcd_data}), 'h38);
        check({busy, init_done} == 2'b10, "reset_busy_done", int'({busy, init_done}), 2);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        push_init();
        push_refresh(-1, 0, '0, '0);
        vecs.push_back(idle_vec());
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
